// File: rtl/melody_sequencer.sv
// Melody sequencer: fetches 4-byte notes from a byte ROM and
// plays each one as a square wave on the buzzer pin.
module melody_sequencer #(
    parameter int CLOCK_HZ   = 25000000,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start_i,
    input  logic                  Stop_i,
    output logic                  RomReadEnable_o,
    output logic [ADDR_WIDTH-1:0] RomAddress_o,
    input  logic [7:0]            RomData_i,
    output logic                  Buzzer_o,
    output logic                  Busy_o,
    output logic                  Done_o
);

    localparam int DIV   = CLOCK_HZ / 1000000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_fidx;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [15:0]           r_dur;
    logic [15:0]           r_hp;
    logic [15:0]           r_ms;
    logic [15:0]           r_hpcnt;
    logic [9:0]            r_us;
    logic [PRE_W-1:0]      r_presc;
    logic                  r_buzz;
    logic                  r_done;
    logic                  w_re;
    logic                  w_f_last;
    logic                  w_tick;
    logic                  w_ms_wrap;
    logic                  w_ms_done;
    logic                  w_hp_hit;
    logic                  w_toggle;

    assign w_f_last  = (r_state == S_FETCH) && (r_fidx == 3'd4);
    assign w_re      = (r_state == S_FETCH) && (r_fidx != 3'd4);
    assign w_addr    = r_base + ADDR_WIDTH'(r_fidx[1:0]);
    assign w_tick    = (r_presc == PRE_LAST);
    assign w_ms_wrap = w_tick && (r_us == 10'd999);
    assign w_ms_done = w_ms_wrap && ((r_ms + 16'd1) == r_dur);
    assign w_hp_hit  = ((r_hpcnt + 16'd1) == r_hp);
    assign w_toggle  = w_tick && (r_hp != 16'd0) && w_hp_hit;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; Stop overrides everything else
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (Start_i && !Stop_i) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (Stop_i) begin
                    w_next = S_IDLE;
                end else if (w_f_last) begin
                    w_next = (r_dur == 16'd0) ? S_IDLE : S_PLAY;
                end
            end
            S_PLAY: begin
                if (Stop_i) begin
                    w_next = S_IDLE;
                end else if (w_ms_done) begin
                    w_next = S_FETCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; address holds its last strobed value when idle
    always_comb begin
        RomReadEnable_o = w_re;
        RomAddress_o    = w_re ? w_addr : r_addr_q;
        Busy_o          = (r_state != S_IDLE);
        Buzzer_o        = r_buzz;
        Done_o          = r_done;
    end

    // Fetch sequencing, note base pointer and last-address hold
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fidx   <= 3'd0;
            r_base   <= '0;
            r_addr_q <= '0;
        end else begin
            if ((r_state == S_FETCH) && (w_next == S_FETCH)) begin
                r_fidx <= r_fidx + 3'd1;
            end else begin
                r_fidx <= 3'd0;
            end
            if (w_next == S_IDLE) begin
                r_base <= '0;
            end else if (w_f_last && (w_next == S_PLAY)) begin
                r_base <= r_base + ADDR_WIDTH'(4);
            end
            if (w_re) begin
                r_addr_q <= w_addr;
            end
        end
    end

    // Assemble the big-endian note fields one byte per fetch cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_dur <= 16'd0;
            r_hp  <= 16'd0;
        end else if (r_state == S_FETCH) begin
            case (r_fidx)
                3'd1:    r_dur[15:8] <= RomData_i;
                3'd2:    r_dur[7:0]  <= RomData_i;
                3'd3:    r_hp[15:8]  <= RomData_i;
                3'd4:    r_hp[7:0]   <= RomData_i;
                default: ;
            endcase
        end
    end

    // End-marker pulse, suppressed by a simultaneous Stop
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_f_last && (r_dur == 16'd0) && !Stop_i;
        end
    end

    // Timebase: us prescaler, us-in-ms, ms and half-period counters
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_presc <= '0;
            r_us    <= 10'd0;
            r_ms    <= 16'd0;
            r_hpcnt <= 16'd0;
        end else if (r_state != S_PLAY) begin
            r_presc <= '0;
            r_us    <= 10'd0;
            r_ms    <= 16'd0;
            r_hpcnt <= 16'd0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
            if (w_tick) begin
                r_us <= (r_us == 10'd999) ? 10'd0 : r_us + 10'd1;
                if (w_ms_wrap) begin
                    r_ms <= r_ms + 16'd1;
                end
                if (r_hp != 16'd0) begin
                    r_hpcnt <= w_hp_hit ? 16'd0 : r_hpcnt + 16'd1;
                end
            end
        end
    end

    // Buzzer toggles only while playing; forced low otherwise
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_buzz <= 1'b0;
        end else if (w_next != S_PLAY) begin
            r_buzz <= 1'b0;
        end else if ((r_state == S_PLAY) && w_toggle) begin
            r_buzz <= ~r_buzz;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: vector table, directed melody
// runs, async reset, address wrap and randomized melodies.
module tb_melody_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Start_i;
    logic        Stop_i;
    logic        RomReadEnable_o;
    logic [11:0] RomAddress_o;
    logic [7:0]  RomData_i;
    logic        Buzzer_o;
    logic        Busy_o;
    logic        Done_o;

    logic        Start2;
    logic        Stop2;
    logic        re2;
    logic [3:0]  addr2;
    logic [7:0]  data2;
    logic        buz2;
    logic        busy2;
    logic        done2;

    logic [7:0]  rom  [0:4095];
    logic [7:0]  rom2 [0:15];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        re;
        logic        buz;
        logic [11:0] addr;
    } exp_t;

    typedef struct {
        logic        start;
        logic        stop;
        logic        busy;
        logic        re;
        logic        done;
        logic        buz;
        logic [11:0] addr;
    } vec_t;

    melody_sequencer #(
        .CLOCK_HZ  (2000000),
        .ADDR_WIDTH(12)
    ) u_dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start_i        (Start_i),
        .Stop_i         (Stop_i),
        .RomReadEnable_o(RomReadEnable_o),
        .RomAddress_o   (RomAddress_o),
        .RomData_i      (RomData_i),
        .Buzzer_o       (Buzzer_o),
        .Busy_o         (Busy_o),
        .Done_o         (Done_o)
    );

    melody_sequencer #(
        .CLOCK_HZ  (2000000),
        .ADDR_WIDTH(4)
    ) u_wrap (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start_i        (Start2),
        .Stop_i         (Stop2),
        .RomReadEnable_o(re2),
        .RomAddress_o   (addr2),
        .RomData_i      (data2),
        .Buzzer_o       (buz2),
        .Busy_o         (busy2),
        .Done_o         (done2)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) begin
        if (RomReadEnable_o) RomData_i <= rom[RomAddress_o];
        if (re2) data2 <= rom2[addr2];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put_note(input int a, input int dur, input int hp);
        rom[a]   = 8'(dur >> 8);
        rom[a+1] = 8'(dur);
        rom[a+2] = 8'(hp >> 8);
        rom[a+3] = 8'(hp);
    endtask

    task automatic put_note2(input int a, input int dur, input int hp);
        rom2[a]   = 8'(dur >> 8);
        rom2[a+1] = 8'(dur);
        rom2[a+2] = 8'(hp >> 8);
        rom2[a+3] = 8'(hp);
    endtask

    // Timeline model: t=0 is the first fetch cycle after Start.
    // Each note = 5 fetch cycles then dur*2000 play cycles.
    function automatic exp_t model_run(input int t);
        exp_t e;
        int   pos;
        int   base;
        int   dur;
        int   hp;
        int   len;
        e    = '0;
        pos  = t;
        base = 0;
        for (int n = 0; n < 2048; n++) begin
            if (pos < 4) begin
                e.busy = 1'b1;
                e.re   = 1'b1;
                e.addr = 12'(base + pos);
                return e;
            end
            e.addr = 12'(base + 3);
            if (pos == 4) begin
                e.busy = 1'b1;
                return e;
            end
            pos -= 5;
            dur = int'({rom[base], rom[base+1]});
            hp  = int'({rom[base+2], rom[base+3]});
            if (dur == 0) begin
                e.done = (pos == 0);
                return e;
            end
            len = dur * 2000;
            if (pos < len) begin
                e.busy = 1'b1;
                e.buz  = (hp != 0) && (((pos / (2 * hp)) % 2) == 1);
                return e;
            end
            pos -= len;
            base = (base + 4) % 4096;
        end
        return e;
    endfunction

    function automatic exp_t model(input int t, input int stop_t);
        exp_t e;
        if (stop_t >= 0 && t > stop_t) begin
            e      = model_run(stop_t);
            e.busy = 1'b0;
            e.done = 1'b0;
            e.re   = 1'b0;
            e.buz  = 1'b0;
            return e;
        end
        return model_run(t);
    endfunction

    // Start a melody and compare every cycle against the model
    task automatic run_melody(input int stop_t, input int pulse_t,
                              input int limit, output int edges,
                              output int dones, output int busy_n);
        exp_t e;
        exp_t a;
        logic prev;
        int   t;
        edges  = 0;
        dones  = 0;
        busy_n = 0;
        t      = 0;
        prev   = 1'b0;
        Start_i = 1'b1;
        @(negedge Clock);
        Start_i = 1'b0;
        forever begin
            e = model(t, stop_t);
            a = {Busy_o, Done_o, RomReadEnable_o, Buzzer_o, RomAddress_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle %0d busy/done/re/buz/addr: got %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                         t, a.busy, a.done, a.re, a.buz, a.addr,
                         e.busy, e.done, e.re, e.buz, e.addr);
                break;
            end
            if (Buzzer_o !== prev) edges++;
            prev = Buzzer_o;
            if (Done_o) dones++;
            if (Busy_o) busy_n++;
            if (t >= 1 && !e.busy && !e.done) break;
            if (t >= limit) begin
                errors++;
                $display("FAIL run timeout: got %0d cycles required end by %0d",
                         t, limit);
                break;
            end
            Start_i = (t == pulse_t) && e.busy;
            Stop_i  = (t == stop_t);
            @(negedge Clock);
            t++;
        end
        Start_i = 1'b0;
        Stop_i  = 1'b1;
        @(negedge Clock);
        Stop_i  = 1'b0;
        @(negedge Clock);
    endtask

    vec_t vecs [12];

    initial begin
        int   edges;
        int   dones;
        int   busy_n;
        int   n;
        int   t;
        int   q[$];
        logic prev;
        int   done_t;
        int   stop_t;
        int   pulse_t;
        int   nn;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h002};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h003};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h003};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h003};

        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        for (int i = 0; i < 16; i++) rom2[i] = 8'h00;
        put_note(0,  5, 100);
        put_note(4,  2, 0);
        put_note(8,  8, 500);
        put_note(12, 5, 50);

        Reset   = 1'b1;
        Start_i = 1'b0;
        Stop_i  = 1'b0;
        Start2  = 1'b0;
        Stop2   = 1'b0;
        RomData_i = 8'h00;
        data2   = 8'h00;
        repeat (3) @(negedge Clock);
        chk("reset busy",   Busy_o, 0);
        chk("reset done",   Done_o, 0);
        chk("reset re",     RomReadEnable_o, 0);
        chk("reset addr",   RomAddress_o, 0);
        chk("reset buzzer", Buzzer_o, 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Single-cycle input vectors around IDLE and FETCH
        for (int i = 0; i < 12; i++) begin
            Start_i = vecs[i].start;
            Stop_i  = vecs[i].stop;
            @(negedge Clock);
            chk($sformatf("vec%0d busy", i), Busy_o, vecs[i].busy);
            chk($sformatf("vec%0d re", i), RomReadEnable_o, vecs[i].re);
            chk($sformatf("vec%0d addr", i), RomAddress_o, vecs[i].addr);
            chk($sformatf("vec%0d done", i), Done_o, vecs[i].done);
            chk($sformatf("vec%0d buz", i), Buzzer_o, vecs[i].buz);
        end
        Start_i = 1'b0;
        Stop_i  = 1'b0;
        @(negedge Clock);

        // Full melody with a Start re-pulse during note 2
        run_melody(-1, 15000, 45000, edges, dones, busy_n);
        chk("full toggles", edges, 166);
        chk("full done pulses", dones, 1);
        chk("full busy cycles", busy_n, 40025);

        // Stop 3000 cycles into note 0, then refetch from 0
        run_melody(3005, -1, 20000, edges, dones, busy_n);
        chk("stop done pulses", dones, 0);
        chk("stop busy cycles", busy_n, 3006);
        run_melody(6, -1, 100, edges, dones, busy_n);
        chk("refetch busy cycles", busy_n, 7);

        // Async reset while the buzzer is high
        Start_i = 1'b1;
        @(negedge Clock);
        Start_i = 1'b0;
        n = 0;
        while (Buzzer_o !== 1'b1 && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        chk("buzzer high before reset", Buzzer_o, 1);
        #1 Reset = 1'b1;
        #1;
        chk("async reset buzzer", Buzzer_o, 0);
        chk("async reset busy", Busy_o, 0);
        chk("async reset addr", RomAddress_o, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // Address wrap on a 4-bit instance; entry 0 becomes the end
        put_note2(0,  1, 0);
        put_note2(4,  1, 0);
        put_note2(8,  1, 0);
        put_note2(12, 1, 10);
        Start2 = 1'b1;
        @(negedge Clock);
        Start2 = 1'b0;
        t = 0;
        prev = 1'b0;
        edges = 0;
        dones = 0;
        done_t = -1;
        while (t < 9000) begin
            if (re2) q.push_back(int'(addr2));
            if (buz2 !== prev) edges++;
            prev = buz2;
            if (done2) begin
                dones++;
                done_t = t;
            end
            if (t == 4) begin
                rom2[0] = 8'h00;
                rom2[1] = 8'h00;
            end
            if (t > 0 && !busy2 && !done2) break;
            @(negedge Clock);
            t++;
        end
        chk("wrap finished in time", int'(t < 9000), 1);
        chk("wrap strobe count", q.size(), 20);
        if (q.size() >= 20) begin
            chk("wrap addr C", q[12], 12);
            chk("wrap addr F", q[15], 15);
            chk("wrap addr 0", q[16], 0);
            chk("wrap addr 3", q[19], 3);
        end
        chk("wrap done pulses", dones, 1);
        chk("wrap done cycle", done_t, 8025);
        chk("wrap toggles", edges, 100);

        // Randomized short melodies with random stop / start pulses
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) rom[i] = 8'h00;
            nn = $urandom_range(1, 3);
            for (int k = 0; k < nn; k++) begin
                if ($urandom_range(0, 3) == 0) put_note(4 * k, 1, 0);
                else put_note(4 * k, 1, $urandom_range(1, 250));
            end
            stop_t  = ($urandom_range(0, 1) == 1) ?
                      int'($urandom_range(0, nn * 2005)) : -1;
            pulse_t = $urandom_range(0, nn * 2005);
            run_melody(stop_t, pulse_t, 8000, edges, dones, busy_n);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Plays a note list held in the melody ROM by sequencing its read port and driving a square-wave buzzer output.
- Each ROM note entry is 4 bytes, big-endian:
  - bytes 0-1: Duration in ms (16 bit).
  - bytes 2-3: HalfPeriod in µs (16 bit). HalfPeriod = 10^6/(2·Freq); HalfPeriod 0 means silence.
- An entry with Duration 0 terminates the melody.
- Sits between the ROM and the buzzer pin; a user start/stop pair controls it.

Parameters:
- CLOCK_HZ, 25000000, system clock frequency. Must be an integer multiple of 1000000 and at least 2000000.
- ADDR_WIDTH, 12, ROM address width.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Start_i  in  1  level or pulse; sampled in IDLE only.
- Stop_i  in  1  abort playback; has priority over Start_i.
- RomReadEnable_o  out  1  ROM read strobe.
- RomAddress_o  out  ADDR_WIDTH  ROM byte address.
- RomData_i  in  8  ROM data, registered in the ROM (valid the cycle after the strobe).
- Buzzer_o  out  1  square-wave output.
- Busy_o  out  1  high in every state except IDLE.
- Done_o  out  1  one-cycle pulse when the end marker is fetched.

Behaviour:
- Reset (asynchronous, active-high) forces the following:
  - State = IDLE, base address = 0.
  - RomReadEnable_o = 0, RomAddress_o = 0.
  - Buzzer_o = 0, Busy_o = 0, Done_o = 0.
  - All counters and note registers = 0.
- Reset asserted mid-note has the same effect immediately; Buzzer_o drops in the same cycle.
- IDLE:
  - Start_i=1 and Stop_i=0: base := 0, go to FETCH.
  - Otherwise remain in IDLE.
- FETCH, 5 cycles F0..F4:
  - F0: RomReadEnable_o=1, RomAddress_o=base.
  - F1: RomReadEnable_o=1, RomAddress_o=base+1; capture RomData_i into Dur[15:8].
  - F2: RomReadEnable_o=1, RomAddress_o=base+2; capture RomData_i into Dur[7:0].
  - F3: RomReadEnable_o=1, RomAddress_o=base+3; capture RomData_i into Hp[15:8].
  - F4: RomReadEnable_o=0; capture RomData_i into Hp[7:0].
  - End of F4, decided on the assembled value:
    - Dur==0: Done_o=1 for the next cycle, go to IDLE.
    - Otherwise: base := base+4, go to PLAY.
  - Address arithmetic is modulo 2^ADDR_WIDTH, so the entry at 0xFFC is followed by 0x000 and playback continues.
  - RomReadEnable_o is 0 in every state other than F0-F3.
  - RomAddress_o holds its last value whenever RomReadEnable_o=0.
- PLAY:
  - On entry, clear the µs prescaler, the µs-in-ms counter, the ms counter and the half-period counter; Buzzer_o=0.
  - A µs tick fires every CLOCK_HZ/10^6 cycles.
  - Every 1000 µs ticks, the ms counter increments.
  - When the ms counter reaches Dur, go to FETCH. Note length is exactly Dur·CLOCK_HZ/1000 cycles.
  - Hp≠0: the half-period counter counts µs ticks; when it reaches Hp it clears and Buzzer_o toggles. The first toggle occurs Hp µs after note start.
  - Hp==0: Buzzer_o held 0 for the whole note.
- Buzzer_o is forced to 0 in IDLE and FETCH. The 5-cycle fetch gap between notes is accepted.
- Stop_i=1 in any state: next state IDLE, Buzzer_o=0, RomReadEnable_o=0, no Done_o pulse. Base is not retained; the next Start_i begins at address 0.
- Start_i while Busy_o=1 is ignored.
- Done_o and Stop_i asserted in the same cycle: Stop wins and no pulse is issued.

Test Plan:
All scenarios use CLOCK_HZ=2000000 (2 cycles/µs) and the melody ROM model loaded with 4 notes followed by zero-filled addresses:
- Note 0: 5 ms, Hp 100.
- Note 1: 2 ms, silence.
- Note 2: 8 ms, Hp 500.
- Note 3: 5 ms, Hp 50.

1. Reset released, Start_i pulse:
   - Expected address/strobe sequence: 0,1,2,3 with strobe high 4 cycles.
   - Note 0 then gives 50 Buzzer_o toggles, 200 cycles apart, over 10000 cycles.
2. Full melody:
   - Note 1: Buzzer_o low for 4000 cycles.
   - Note 2: 16 toggles, 1000 cycles apart.
   - Note 3: 100 toggles, 100 cycles apart.
   - Fetch at 0x010 returns Dur=0, giving exactly one Done_o pulse, then Busy_o=0.
   - Total time from start = 40000 play cycles + 25 fetch cycles.
3. Stop_i asserted at cycle 3000 of note 0:
   - Buzzer_o=0 and Busy_o=0 next cycle; no Done_o pulse.
   - A following Start_i refetches from address 0.
4. Start_i re-pulsed during note 2:
   - No change in addresses or toggle timing.
5. Start_i=Stop_i=1 in IDLE:
   - Remains IDLE, RomReadEnable_o stays 0.
   - Asynchronous Reset mid-note drops Buzzer_o without waiting for a Clock edge.
6. ROM model with note at 0xFFC (1 ms, Hp 10) and terminator at 0x000, start forced with base 0xFFC via a bench-loaded ROM image at 0x000 jumping there:
   - Verify the address wraps 0xFFF→0x000.
   - Verify Done_o pulses after the 0xFFC note.
